// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA/XTEA block engine.
// Imported by tea_cycle and tea_block_engine.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic {ALG_TEA, ALG_XTEA} alg_t;

    typedef logic [63:0]  block_t;
    typedef logic [127:0] key_t;

    // Key word k[i], with k0 held in the most significant 32 bits.
    function automatic logic [31:0] key_word(input key_t k, input logic [1:0] i);
        logic [31:0] w;
        case (i)
            2'd0:    w = k[127:96];
            2'd1:    w = k[95:64];
            2'd2:    w = k[63:32];
            default: w = k[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tea_cycle.sv
// One full TEA/XTEA cycle (two Feistel half-rounds), purely combinational.
// The XTEA datapath exists only when XTEA_EN is defined.
module tea_cycle
    import tea_pkg::*;
#(
    parameter logic [31:0] DELTA = TEA_DELTA
) (
    input  block_t      v,
    input  key_t        key,
    input  logic [31:0] sum,
    input  logic        decrypt,
    input  alg_t        alg,
    output block_t      v_next,
    output logic [31:0] sum_next
);

    logic [31:0] v0, v1, k0, k1, k2, k3;
    logic [31:0] sum_up, sum_dn;
    logic [31:0] te0, te1, td0, td1;

    function automatic logic [31:0] tea_f(input logic [31:0] x, s, ka, kb);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    assign {v0, v1}         = v;
    assign {k0, k1, k2, k3} = key;
    assign sum_up           = sum + DELTA;
    assign sum_dn           = sum - DELTA;
    // Both algorithms step the sum identically per cycle.
    assign sum_next         = decrypt ? sum_dn : sum_up;

    assign te0 = v0 + tea_f(v1, sum, k0, k1);
    assign te1 = v1 + tea_f(te0, sum, k2, k3);
    assign td1 = v1 - tea_f(v0, sum, k2, k3);
    assign td0 = v0 - tea_f(td1, sum, k0, k1);

`ifdef XTEA_EN
    logic [31:0] xe0, xe1, xd0, xd1;

    function automatic logic [31:0] mix(input logic [31:0] x);
        return ((x << 4) ^ (x >> 5)) + x;
    endfunction

    assign xe0 = v0 + (mix(v1)  ^ (sum    + key_word(key, sum[1:0])));
    assign xe1 = v1 + (mix(xe0) ^ (sum_up + key_word(key, sum_up[12:11])));
    assign xd1 = v1 - (mix(v0)  ^ (sum    + key_word(key, sum[12:11])));
    assign xd0 = v0 - (mix(xd1) ^ (sum_dn + key_word(key, sum_dn[1:0])));

    always_comb begin
        if (alg == ALG_XTEA) begin
            v_next = decrypt ? {xd0, xd1} : {xe0, xe1};
        end else begin
            v_next = decrypt ? {td0, td1} : {te0, te1};
        end
    end
`else
    logic unused_alg;
    assign unused_alg = alg;
    assign v_next     = decrypt ? {td0, td1} : {te0, te1};
`endif

endmodule

// File: rtl/tea_block_engine.sv
// TEA (and XTEA when XTEA_EN is defined) block engine with valid/ready
// handshakes, per-block key latch and UNROLL cycles per clock.
module tea_block_engine
    import tea_pkg::*;
#(
    parameter int          ROUNDS = 32,
    parameter int          UNROLL = 1,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [127:0] in_key,
    input  logic         in_decrypt,
    input  logic         in_alg,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);

    localparam int          CW      = $clog2(ROUNDS + 1);
    localparam logic [31:0] SUM_DEC = 32'(ROUNDS) * DELTA;

    state_t      state, state_next;
    logic [CW-1:0] cnt;
    block_t      v_q, out_q;
    key_t        key_q;
    logic [31:0] sum_q, sum_init;
    logic        dec_q;
    alg_t        alg_q, alg_in;
    logic        accept, last;
    logic        out_valid_q, busy_q;

    block_t      v_chain   [UNROLL+1];
    logic [31:0] sum_chain [UNROLL+1];

`ifdef XTEA_EN
    assign alg_in = alg_t'(in_alg);
`else
    logic unused_in_alg;
    assign unused_in_alg = in_alg;
    assign alg_in        = ALG_TEA;
`endif

    assign sum_init = in_decrypt            ? SUM_DEC :
                      (alg_in == ALG_XTEA)  ? 32'h0   : DELTA;
    assign last     = (cnt == CW'(ROUNDS - UNROLL));
    assign accept   = in_valid & in_ready;

    assign v_chain[0]   = v_q;
    assign sum_chain[0] = sum_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_unroll
        tea_cycle #(.DELTA(DELTA)) u_cycle (
            .v        (v_chain[g]),
            .key      (key_q),
            .sum      (sum_chain[g]),
            .decrypt  (dec_q),
            .alg      (alg_q),
            .v_next   (v_chain[g+1]),
            .sum_next (sum_chain[g+1])
        );
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_next = in_valid ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_next;
            out_valid_q <= (state_next == DONE);
            busy_q      <= (state_next == RUN);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q   <= '0;
            out_q <= '0;
            key_q <= '0;
            sum_q <= '0;
            cnt   <= '0;
            dec_q <= 1'b0;
            alg_q <= ALG_TEA;
        end else if (accept) begin
            v_q   <= in_data;
            key_q <= in_key;
            sum_q <= sum_init;
            dec_q <= in_decrypt;
            alg_q <= alg_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            v_q   <= v_chain[UNROLL];
            sum_q <= sum_chain[UNROLL];
            cnt   <= cnt + CW'(UNROLL);
            if (last) out_q <= v_chain[UNROLL];
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_tea_block_engine.sv
// Directed self-checking bench: instance 0 runs UNROLL=1, instance 1 UNROLL=4.
// XTEA vectors are exercised only when XTEA_EN is defined.
module tb_tea_block_engine;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         iv [2], ir [2], idec [2], ialg [2], ov [2], ordy [2], bsy [2];
    logic [63:0]  idata [2], od [2];
    logic [127:0] ikey [2];

    int checks = 0;
    int errors = 0;

    localparam logic [63:0]  TEA_ZERO_CT  = 64'h41ea3a0a_94baa940;
    localparam logic [63:0]  XTEA_ZERO_CT = 64'hdee9d4d8_f7131ed9;
    localparam logic [127:0] KEY_A        = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] KEY_B        = 128'hdeadbeef_0badf00d_13572468_a5a5c3c3;

    always #5 clk = ~clk;

    tea_block_engine #(.ROUNDS(32), .UNROLL(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(idata[0]), .in_key(ikey[0]), .in_decrypt(idec[0]), .in_alg(ialg[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bsy[0])
    );

    tea_block_engine #(.ROUNDS(32), .UNROLL(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(idata[1]), .in_key(ikey[1]), .in_decrypt(idec[1]), .in_alg(ialg[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bsy[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Offers one block, scrambles the inputs while it runs, waits (bounded) for out_valid.
    task automatic run_block(input int s, input logic [63:0] d, input logic [127:0] k,
                             input logic dec, input logic alg,
                             output logic [63:0] res, output int lat, output int bcnt);
        int guard = 0;
        @(negedge clk);
        while (!ir[s] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        idata[s] = d; ikey[s] = k; idec[s] = dec; ialg[s] = alg; iv[s] = 1'b1;
        @(posedge clk); #1;
        idata[s] = ~d; ikey[s] = ~k; idec[s] = ~dec;
        lat = 0; bcnt = 0;
        while (!ov[s] && lat < 200) begin
            if (bsy[s]) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        iv[s] = 1'b0;
        res   = od[s];
    endtask

    task automatic pop(input int s);
        @(negedge clk);
        ordy[s] = 1'b1;
        @(posedge clk); #1;
        ordy[s] = 1'b0;
    endtask

    initial begin
        logic [63:0] res, ct;
        int lat, bcnt;

        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; idec[i] = 1'b0; ialg[i] = 1'b0; ordy[i] = 1'b0;
            idata[i] = '0; ikey[i] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready",  64'(ir[i]),  64'd1);
            check("rst_out_valid", 64'(ov[i]),  64'd0);
            check("rst_busy",      64'(bsy[i]), 64'd0);
            check("rst_out_data",  od[i],       64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        run_block(0, 64'd0, 128'd0, 1'b0, 1'b0, res, lat, bcnt);
        check("tea_enc_zero", res, TEA_ZERO_CT);
        check("tea_enc_lat",  64'(lat),  64'd32);
        check("tea_enc_busy", 64'(bcnt), 64'd32);
        pop(0);
        check("idle_after_pop", 64'(ir[0]), 64'd1);
        check("ov_after_pop",   64'(ov[0]), 64'd0);

        run_block(0, TEA_ZERO_CT, 128'd0, 1'b1, 1'b0, res, lat, bcnt);
        check("tea_dec_zero", res, 64'd0);
        check("tea_dec_lat",  64'(lat), 64'd32);
        pop(0);

        run_block(0, 64'hfeedface_c0ffee00, KEY_B, 1'b0, 1'b0, ct, lat, bcnt);
        pop(0);
        run_block(0, ct, KEY_B, 1'b1, 1'b0, res, lat, bcnt);
        check("tea_roundtrip_b", res, 64'hfeedface_c0ffee00);
        pop(0);

`ifdef XTEA_EN
        run_block(0, 64'd0, 128'd0, 1'b0, 1'b1, res, lat, bcnt);
        check("xtea_enc_zero", res, XTEA_ZERO_CT);
        pop(0);
        run_block(0, XTEA_ZERO_CT, 128'd0, 1'b1, 1'b1, res, lat, bcnt);
        check("xtea_dec_zero", res, 64'd0);
        pop(0);
        run_block(1, 64'h00000001_80000000, KEY_A, 1'b0, 1'b1, ct, lat, bcnt);
        pop(1);
        run_block(1, ct, KEY_A, 1'b1, 1'b1, res, lat, bcnt);
        check("xtea_u4_roundtrip", res, 64'h00000001_80000000);
        pop(1);
`else
        run_block(0, 64'd0, 128'd0, 1'b0, 1'b1, res, lat, bcnt);
        check("alg1_as_tea", res, TEA_ZERO_CT);
        pop(0);
`endif

        run_block(1, 64'd0, 128'd0, 1'b0, 1'b0, res, lat, bcnt);
        check("u4_enc_zero", res, TEA_ZERO_CT);
        check("u4_enc_lat",  64'(lat),  64'd8);
        check("u4_enc_busy", 64'(bcnt), 64'd8);
        pop(1);
        run_block(1, 64'h01234567_89abcdef, KEY_A, 1'b0, 1'b0, ct, lat, bcnt);
        check("u4_enc_lat_a", 64'(lat), 64'd8);
        pop(1);
        run_block(1, ct, KEY_A, 1'b1, 1'b0, res, lat, bcnt);
        check("u4_roundtrip_a", res, 64'h01234567_89abcdef);
        check("u4_dec_lat_a",   64'(lat), 64'd8);
        pop(1);

        // Backpressure, then a handshake overlapping a new accept.
        run_block(0, 64'd0, 128'd0, 1'b0, 1'b0, res, lat, bcnt);
        check("bp_first", res, TEA_ZERO_CT);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_hold_data",     od[0],      TEA_ZERO_CT);
            check("bp_hold_valid",    64'(ov[0]), 64'd1);
            check("bp_hold_in_ready", 64'(ir[0]), 64'd0);
        end
        @(negedge clk);
        idata[0] = TEA_ZERO_CT; ikey[0] = '0; idec[0] = 1'b1; ialg[0] = 1'b0;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        #1;
        check("bp_in_ready_follows", 64'(ir[0]), 64'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0; ordy[0] = 1'b0; idata[0] = '1;
        check("b2b_ov_drop", 64'(ov[0]),  64'd0);
        check("b2b_busy",    64'(bsy[0]), 64'd1);
        lat = 0;
        while (!ov[0] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_lat",    64'(lat), 64'd32);
        check("b2b_result", od[0],    64'd0);
        pop(0);

        // Reset in the middle of a run.
        @(negedge clk);
        idata[0] = 64'hffffffff_ffffffff; ikey[0] = KEY_A; idec[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_ov",       64'(ov[0]),  64'd0);
        check("midrst_in_ready", 64'(ir[0]),  64'd1);
        check("midrst_busy",     64'(bsy[0]), 64'd0);
        check("midrst_data",     od[0],       64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_block(0, 64'd0, 128'd0, 1'b0, 1'b0, res, lat, bcnt);
        check("post_rst_enc", res, TEA_ZERO_CT);
        check("post_rst_lat", 64'(lat), 64'd32);
        pop(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tea_block_engine.md
Name: tea_block_engine

Overview:
Parametrised successor to the single-mode TEA core. Runs TEA, or XTEA when compiled in, over one 64-bit block with encrypt/decrypt selected per block. Uses valid/ready handshakes on input and output, latches the key per block, and unrolls a configurable number of cycles per clock. Sits between the host-side interface/key register and any chaining/mode logic.

Parameters:
ROUNDS, 32, number of TEA/XTEA cycles (each cycle = two Feistel half-rounds); must be a multiple of UNROLL.
UNROLL, 1, cycles computed per clock; legal values 1, 2, 4, 8.
DELTA, 32'h9E3779B9, key-schedule constant.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  block offered
in_ready  out  1  engine can accept a block
in_data  in  64  block; v0 = [63:32], v1 = [31:0]
in_key  in  128  k0 = [127:96], k1 = [95:64], k2 = [63:32], k3 = [31:0]
in_decrypt  in  1  0 = encrypt, 1 = decrypt
in_alg  in  1  0 = TEA, 1 = XTEA
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  64  result, same word order as in_data
busy  out  1  state == RUN

Behaviour:
- Interface: single clock clk; reset_n is asynchronous, active-low.
- States:
  - IDLE: in_ready = 1.
  - RUN: in_ready = 0.
  - DONE: out_valid = 1; in_ready = out_ready.
- Transitions:
  - Accept when in_valid & in_ready.
  - On accept, latch in_data, in_key, in_decrypt and in_alg; go to RUN; clear the cycle counter.
  - Initial sum:
    - TEA encrypt: DELTA.
    - TEA decrypt: ROUNDS*DELTA mod 2^32.
    - XTEA encrypt: 0.
    - XTEA decrypt: ROUNDS*DELTA mod 2^32.
- RUN:
  - Each clock applies UNROLL cycles and advances the counter by UNROLL.
  - After ROUNDS/UNROLL clocks, go to DONE.
  - Latency from accept edge to out_valid high = ROUNDS/UNROLL clocks (32 at defaults).
- TEA encrypt cycle:
  - v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1)
  - v1 += ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
  - sum += DELTA
- TEA decrypt: mirror of encrypt — update v1 first, then v0, with subtraction; then sum -= DELTA.
- XTEA encrypt cycle:
  - v0 += (((v1<<4)^(v1>>5))+v1) ^ (sum+k[sum&3])
  - sum += DELTA
  - v1 += (((v0<<4)^(v0>>5))+v0) ^ (sum+k[(sum>>11)&3])
- XTEA decrypt is the exact inverse.
- Arithmetic: all arithmetic is mod 2^32. Shifts are logical.
- DONE:
  - out_data holds the result until out_valid & out_ready.
  - Handshake with no new accept in the same cycle: go to IDLE.
  - Handshake and a simultaneous new accept: go directly to RUN; out_valid drops the next cycle. Back-to-back throughput = 1 block per ROUNDS/UNROLL+1 clocks.
- in_valid in RUN is ignored; the latched key and mode are unaffected.
- Input changes after accept have no effect.
- Async reset, at any time including mid-RUN:
  - state = IDLE, out_valid = 0, out_data = 0, busy = 0.
  - Counter, sum and latched key all cleared.
  - The in-flight block is discarded.
- Outputs are registered, except in_ready, which is combinational from state and out_ready.

Optional Feature:
XTEA_EN
- Defined: XTEA datapath is present; in_alg selects the algorithm per block.
- Undefined:
  - in_alg is ignored and treated as 0 (TEA only).
  - No XTEA logic is synthesised.
  - A block requested with in_alg = 1 is processed as TEA.

Decomposition:
- Package tea_pkg:
  - TEA_DELTA constant.
  - state typedef (IDLE, RUN, DONE).
  - alg typedef (ALG_TEA, ALG_XTEA).
  - 64-bit block and 128-bit key typedefs.
- Sub-module tea_cycle: combinational, one full cycle.
  - Inputs: v, key, sum, decrypt, alg.
  - Outputs: v_next, sum_next.
  - Instantiated UNROLL times as a chain inside tea_block_engine.

Test Plan:
- TEA encrypt, key 0, in_data 0 -> after 32 clocks out_data = 41ea3a0a_94baa940; busy high for exactly 32 clocks.
- TEA decrypt, key 0, in_data 41ea3a0a_94baa940 -> 00000000_00000000.
- XTEA encrypt (XTEA_EN defined), key 0, in_data 0 -> dee9d4d8_f7131ed9; decrypt of that value returns 0.
- UNROLL = 4, random key/data, encrypt then decrypt -> original data; out_valid after exactly 8 clocks.
- Backpressure: hold out_ready = 0 for 10 clocks -> out_data stable, in_ready = 0. Raise out_ready with in_valid = 1 -> new block accepted the same cycle; next result after 32 further clocks.
- Deassert reset_n mid-RUN (clock 15) -> out_valid = 0 and in_ready = 1 immediately; next block computes correctly.
